// File: rtl/reg_file_pkg.sv
// Shared constants and helpers for the two-read/one-write register file.
package reg_file_pkg;

  localparam int unsigned ZERO_R0_OFF = 0;
  localparam int unsigned ZERO_R0_ON  = 1;

  localparam int unsigned RST_VAL_DEFAULT = 0;

  function automatic int unsigned awidth_f(input int unsigned nregs);
    return $clog2(nregs);
  endfunction

endpackage

// File: rtl/reg_file_2r1w_reg_cell.sv
// One storage word: enable flop with asynchronous active-high reset to RST_VAL.
module reg_cell #(
  parameter int unsigned       DWIDTH  = 16,
  parameter logic [DWIDTH-1:0] RST_VAL = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [DWIDTH-1:0] d,
  output logic [DWIDTH-1:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// Parametrised 2-read/1-write register file with registered operands and
// same-cycle write-to-read forwarding.
module reg_file_2r1w
  import reg_file_pkg::*;
#(
  parameter int unsigned       DWIDTH  = 16,
  parameter int unsigned       NREGS   = 4,
  parameter int unsigned       ZERO_R0 = ZERO_R0_OFF,
  parameter logic [DWIDTH-1:0] RST_VAL = DWIDTH'(RST_VAL_DEFAULT),
  localparam int unsigned      AWIDTH  = awidth_f(NREGS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AWIDTH-1:0] waddr,
  input  logic [DWIDTH-1:0] wdata,
  input  logic              en_in,
  input  logic [AWIDTH-1:0] rd,
  input  logic [AWIDTH-1:0] rs,
  output logic [DWIDTH-1:0] rd_q,
  output logic [DWIDTH-1:0] rs_q,
  output logic              en_out
);

  logic [NREGS-1:0]  wen;
  logic [DWIDTH-1:0] regs [NREGS];
  logic [DWIDTH-1:0] rd_val;
  logic [DWIDTH-1:0] rs_val;

  always_comb begin
    wen = '0;
    if (we) wen[waddr] = 1'b1;
    if (ZERO_R0 == ZERO_R0_ON) wen[0] = 1'b0;
  end

  for (genvar i = 0; i < NREGS; i++) begin : g_cell
    reg_cell #(
      .DWIDTH  (DWIDTH),
      .RST_VAL (RST_VAL)
    ) u_cell (
      .clk (clk),
      .rst (rst),
      .en  (wen[i]),
      .d   (wdata),
      .q   (regs[i])
    );
  end

  // Later assignments win: zero register beats forwarding beats array.
  always_comb begin
    rd_val = regs[rd];
    rs_val = regs[rs];
    if (we && (waddr == rd)) rd_val = wdata;
    if (we && (waddr == rs)) rs_val = wdata;
    if ((ZERO_R0 == ZERO_R0_ON) && (rd == '0)) rd_val = '0;
    if ((ZERO_R0 == ZERO_R0_ON) && (rs == '0)) rs_val = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_q   <= RST_VAL;
      rs_q   <= RST_VAL;
      en_out <= 1'b0;
    end else begin
      en_out <= en_in;
      if (en_in) begin
        rd_q <= rd_val;
        rs_q <= rs_val;
      end
    end
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed bench for reg_file_2r1w: default config and a 32x8 zero-register config.
module tb_reg_file_2r1w;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: DWIDTH=16, NREGS=4, ZERO_R0=0
  logic        we0 = 0, en0 = 0;
  logic [1:0]  wa0 = 0, rd0 = 0, rs0 = 0;
  logic [15:0] wd0 = 0;
  logic [15:0] rdq0, rsq0;
  logic        eno0;

  // Instance 1: DWIDTH=32, NREGS=8, ZERO_R0=1
  logic        we1 = 0, en1 = 0;
  logic [2:0]  wa1 = 0, rd1 = 0, rs1 = 0;
  logic [31:0] wd1 = 0;
  logic [31:0] rdq1, rsq1;
  logic        eno1;

  reg_file_2r1w dut0 (
    .clk(clk), .rst(rst), .we(we0), .waddr(wa0), .wdata(wd0), .en_in(en0),
    .rd(rd0), .rs(rs0), .rd_q(rdq0), .rs_q(rsq0), .en_out(eno0)
  );

  reg_file_2r1w #(.DWIDTH(32), .NREGS(8), .ZERO_R0(1)) dut1 (
    .clk(clk), .rst(rst), .we(we1), .waddr(wa1), .wdata(wd1), .en_in(en1),
    .rd(rd1), .rs(rs1), .rd_q(rdq1), .rs_q(rsq1), .en_out(eno1)
  );

  int errors = 0;
  int checks = 0;
  bit started = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: register contents plus expected outputs.
  logic [15:0] m0 [4];
  logic [31:0] m1 [8];
  logic [15:0] e_rd0, e_rs0;
  logic [31:0] e_rd1, e_rs1;
  logic        e_en0, e_en1;

  function automatic logic [15:0] val0(input int a);
    if (we0 && int'(wa0) == a) return wd0;
    return m0[a];
  endfunction

  function automatic logic [31:0] val1(input int a);
    if (a == 0) return 32'h0;
    if (we1 && int'(wa1) == a) return wd1;
    return m1[a];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      foreach (m0[i]) m0[i] = 16'h0;
      foreach (m1[i]) m1[i] = 32'h0;
      e_rd0 = 0; e_rs0 = 0; e_en0 = 0;
      e_rd1 = 0; e_rs1 = 0; e_en1 = 0;
    end else begin
      if (en0) begin e_rd0 = val0(int'(rd0)); e_rs0 = val0(int'(rs0)); end
      if (en1) begin e_rd1 = val1(int'(rd1)); e_rs1 = val1(int'(rs1)); end
      e_en0 = en0;
      e_en1 = en1;
      if (we0) m0[wa0] = wd0;
      if (we1 && wa1 != 0) m1[wa1] = wd1;
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("model_rd0", 32'(rdq0), 32'(e_rd0));
      chk("model_rs0", 32'(rsq0), 32'(e_rs0));
      chk("model_en0", 32'(eno0), 32'(e_en0));
      chk("model_rd1", rdq1, e_rd1);
      chk("model_rs1", rsq1, e_rs1);
      chk("model_en1", 32'(eno1), 32'(e_en1));
    end
  end

  task automatic set0(input logic we, input logic [1:0] wa, input logic [15:0] wd,
                      input logic en, input logic [1:0] r_d, input logic [1:0] r_s);
    we0 = we; wa0 = wa; wd0 = wd; en0 = en; rd0 = r_d; rs0 = r_s;
  endtask

  task automatic set1(input logic we, input logic [2:0] wa, input logic [31:0] wd,
                      input logic en, input logic [2:0] r_d, input logic [2:0] r_s);
    we1 = we; wa1 = wa; wd1 = wd; en1 = en; rd1 = r_d; rs1 = r_s;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  initial begin
    int en_cnt;
    #1 rst = 1'b1;
    tick(); tick();
    rst = 1'b0;
    started = 1;

    // Reset while a read is in flight.
    set0(1, 2'd2, 16'h7777, 0, 0, 0); tick();
    set0(0, 0, 0, 1, 2'd2, 2'd2); tick();
    chk("pre_rst_rd", 32'(rdq0), 32'h7777);
    chk("pre_rst_en", 32'(eno0), 32'h1);
    set0(0, 0, 0, 1, 2'd2, 2'd2);
    #2 rst = 1'b1;
    #1;
    chk("rst_rd_q", 32'(rdq0), 32'h0);
    chk("rst_rs_q", 32'(rsq0), 32'h0);
    chk("rst_en_out", 32'(eno0), 32'h0);
    tick();
    rst = 1'b0;
    set0(0, 0, 0, 1, 2'd2, 2'd3); tick();
    chk("post_rst_rd", 32'(rdq0), 32'h0);
    chk("post_rst_rs", 32'(rsq0), 32'h0);
    chk("post_rst_en", 32'(eno0), 32'h1);

    // Fill r0..r3, then four back-to-back reads.
    set0(1, 2'd0, 16'h1111, 0, 0, 0); tick();
    set0(1, 2'd1, 16'h2222, 0, 0, 0); tick();
    set0(1, 2'd2, 16'h3333, 0, 0, 0); tick();
    set0(1, 2'd3, 16'h4444, 0, 0, 0); tick();
    en_cnt = 0;
    set0(0, 0, 0, 1, 2'd1, 2'd3);
    for (int i = 0; i < 4; i++) begin
      tick();
      if (eno0) en_cnt++;
    end
    chk("read_rd", 32'(rdq0), 32'h2222);
    chk("read_rs", 32'(rsq0), 32'h4444);
    set0(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 2; i++) begin
      tick();
      if (eno0) en_cnt++;
    end
    chk("en_out_count", 32'(en_cnt), 32'd4);

    // Same-edge forwarding on both ports, then from the array.
    set0(1, 2'd2, 16'h00AA, 0, 0, 0); tick();
    set0(1, 2'd2, 16'hBEEF, 1, 2'd2, 2'd2); tick();
    chk("fwd_rd", 32'(rdq0), 32'hBEEF);
    chk("fwd_rs", 32'(rsq0), 32'hBEEF);
    set0(0, 0, 0, 1, 2'd2, 2'd0); tick();
    chk("array_rd", 32'(rdq0), 32'hBEEF);
    chk("array_rs", 32'(rsq0), 32'h1111);

    // Write to r1 does not leak into a read of r0 / old r1.
    set0(1, 2'd1, 16'h5555, 1, 2'd0, 2'd3); tick();
    set0(1, 2'd1, 16'h5555, 1, 2'd0, 2'd1); tick();
    chk("nonalias_rd", 32'(rdq0), 32'h1111);
    chk("nonalias_rs", 32'(rsq0), 32'h5555);
    set0(1, 2'd1, 16'h6666, 1, 2'd0, 2'd2); tick();
    chk("nonalias2_rs", 32'(rsq0), 32'hBEEF);

    // Hold: outputs keep their values while idle.
    set0(0, 0, 0, 1, 2'd0, 2'd3); tick();
    chk("hold_pre_rd", 32'(rdq0), 32'h1111);
    set0(1, 2'd0, 16'h9999, 0, 2'd0, 2'd0); tick();
    chk("hold_rd", 32'(rdq0), 32'h1111);
    chk("hold_rs", 32'(rsq0), 32'h4444);
    chk("hold_en", 32'(eno0), 32'h0);
    set0(0, 0, 0, 1, 2'd0, 2'd1); tick();
    chk("hold_after_rd", 32'(rdq0), 32'h9999);
    chk("hold_after_rs", 32'(rsq0), 32'h6666);
    set0(0, 0, 0, 0, 0, 0);

    // Zero-register configuration.
    set1(1, 3'd0, 32'hFFFFFFFF, 0, 0, 0); tick();
    set1(1, 3'd7, 32'hCAFEF00D, 0, 0, 0); tick();
    set1(0, 0, 0, 1, 3'd0, 3'd7); tick();
    chk("z_rd0", rdq1, 32'h00000000);
    chk("z_rs7", rsq1, 32'hCAFEF00D);
    set1(1, 3'd0, 32'h12345678, 1, 3'd0, 3'd0); tick();
    chk("z_fwd_rd", rdq1, 32'h0);
    chk("z_fwd_rs", rsq1, 32'h0);
    set1(1, 3'd7, 32'hDEADBEEF, 1, 3'd7, 3'd0); tick();
    chk("z_fwd7_rd", rdq1, 32'hDEADBEEF);
    chk("z_fwd7_rs", rsq1, 32'h0);
    set1(0, 0, 0, 1, 3'd7, 3'd3); tick();
    chk("z_arr7", rdq1, 32'hDEADBEEF);
    chk("z_arr3", rsq1, 32'h0);
    set1(0, 0, 0, 0, 0, 0); tick(); tick();

    started = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
